// File: rtl/melody_pkg.sv
// Shared constants for the melody sequencer: FSM encodings and sequence entry layout.
package melody_pkg;

  localparam int unsigned ENTRY_W  = 4;
  localparam int unsigned REST_BIT = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] SIL  = 2'd2;

  // Extract entry idx from the packed 16-entry sequence word.
  function automatic logic [ENTRY_W-1:0] seq_entry(input logic [63:0] seq,
                                                   input logic [3:0]  idx);
    return seq[idx*ENTRY_W +: ENTRY_W];
  endfunction

endpackage

// File: rtl/melody_seq_dur_timer.sv
// Saturating 16-bit cycle counter with terminal-count compare against a limit.
module dur_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [15:0] limit,
  output logic        tc
);

  logic [15:0] cnt_q, cnt_d;

  // Next count: clear on request, otherwise count up and hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count on the last cycle of a window of 'limit' cycles.
  assign tc = (cnt_q == limit - 16'd1);

endmodule

// File: rtl/melody_seq.sv
// Melody sequencer: steps through packed note entries, gating one of eight
// square-wave channels onto the speaker for DUR cycles followed by GAP cycles of silence.
module melody_seq
  import melody_pkg::*;
#(
  parameter int unsigned DUR  = 4,
  parameter int unsigned GAP  = 2,
  parameter int unsigned LEN  = 8,
  parameter int unsigned LOOP = 0,
  parameter logic [63:0] SEQ  = 64'h0000_0000_7654_3210
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] ch,
  output logic       spk,
  output logic       busy,
  output logic [3:0] step,
  output logic       done
);

  localparam logic [3:0] LAST = 4'(LEN - 1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         step_q, step_d;
  logic               spk_q, spk_d;
  logic               done_q, done_d;
  logic               adv;
  logic               tc;
  logic               clr;
  logic [15:0]        limit;
  logic [ENTRY_W-1:0] entry_d;

  // Counter restarts on every state entry; every tc in PLAY/SIL causes one.
  assign clr   = (state_q == IDLE) || tc || stop;
  assign limit = (state_q == SIL) ? 16'(GAP) : 16'(DUR);

  dur_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .limit (limit),
    .tc    (tc)
  );

  // Next-state, step and done decode; stop overrides everything below reset.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    done_d  = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = PLAY;
          step_d  = '0;
        end
      end
      PLAY: begin
        if (tc) begin
          if (GAP != 0) begin
            state_d = SIL;
          end else begin
            adv = 1'b1;
          end
        end
      end
      SIL: begin
        if (tc) begin
          adv = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
    if (adv) begin
      if (step_q != LAST) begin
        step_d  = step_q + 4'd1;
        state_d = PLAY;
      end else if (LOOP != 0) begin
        step_d  = '0;
        state_d = PLAY;
      end else begin
        step_d  = '0;
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
    if (stop) begin
      state_d = IDLE;
      step_d  = '0;
      done_d  = 1'b0;
    end
  end

  // Speaker source is chosen from the upcoming state and step so spk lines up
  // with the PLAY/SIL windows while still sampling ch one cycle early.
  always_comb begin
    entry_d = seq_entry(SEQ, step_d);
    spk_d   = 1'b0;
    if ((state_d == PLAY) && !entry_d[REST_BIT]) begin
      spk_d = ch[entry_d[2:0]];
    end
  end

  // State, step and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      spk_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      spk_q   <= spk_d;
      done_q  <= done_d;
    end
  end

  assign spk  = spk_q;
  assign busy = (state_q != IDLE);
  assign step = step_q;
  assign done = done_q;

endmodule

// File: tb/tb_melody_seq.sv
// Self-checking bench for melody_seq: four parameterisations checked against a
// timeline model (step and phase derived from elapsed cycles since start).
module tb_melody_seq;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic [7:0] ch  = '0;
  logic       rst_v   [NI];
  logic       start_v [NI];
  logic       stop_v  [NI];
  logic       spk_w   [NI];
  logic       busy_w  [NI];
  logic [3:0] step_w  [NI];
  logic       done_w  [NI];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit ch_rand  = 1'b1;

  always #5 clk = ~clk;

  // ---------------- configurations ----------------
  function automatic int cfg_dur(input int i);
    return (i == 3) ? 1 : 4;
  endfunction
  function automatic int cfg_gap(input int i);
    return (i == 3) ? 0 : 2;
  endfunction
  function automatic int cfg_len(input int i);
    return (i == 2) ? 3 : 8;
  endfunction
  function automatic bit cfg_loop(input int i);
    return (i == 2);
  endfunction
  function automatic logic [63:0] cfg_seq(input int i);
    return (i == 1) ? 64'h0000_0000_7654_3810 : 64'h0000_0000_7654_3210;
  endfunction

  melody_seq #(.DUR(4), .GAP(2), .LEN(8), .LOOP(0), .SEQ(64'h0000_0000_7654_3210)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .stop(stop_v[0]), .ch(ch),
    .spk(spk_w[0]), .busy(busy_w[0]), .step(step_w[0]), .done(done_w[0]));
  melody_seq #(.DUR(4), .GAP(2), .LEN(8), .LOOP(0), .SEQ(64'h0000_0000_7654_3810)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .stop(stop_v[1]), .ch(ch),
    .spk(spk_w[1]), .busy(busy_w[1]), .step(step_w[1]), .done(done_w[1]));
  melody_seq #(.DUR(4), .GAP(2), .LEN(3), .LOOP(1), .SEQ(64'h0000_0000_7654_3210)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .stop(stop_v[2]), .ch(ch),
    .spk(spk_w[2]), .busy(busy_w[2]), .step(step_w[2]), .done(done_w[2]));
  melody_seq #(.DUR(1), .GAP(0), .LEN(8), .LOOP(0), .SEQ(64'h0000_0000_7654_3210)) u_dut3 (
    .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .stop(stop_v[3]), .ch(ch),
    .spk(spk_w[3]), .busy(busy_w[3]), .step(step_w[3]), .done(done_w[3]));

  // ---------------- reference model ----------------
  // Playback is a timeline: t counts cycles since the first busy cycle.
  bit         m_act  [NI];
  int         m_t    [NI];
  bit         m_done [NI];
  logic [7:0] m_pch;

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_act[i] = 1'b0; m_t[i] = 0; m_done[i] = 1'b0;
    end
    m_pch = '0;
  end

  always @(posedge clk) begin
    m_pch <= ch;
    for (int i = 0; i < NI; i++) begin
      int period;
      period = cfg_dur(i) + cfg_gap(i);
      if (rst_v[i]) begin
        m_act[i] <= 1'b0; m_done[i] <= 1'b0; m_t[i] <= 0;
      end else if (m_act[i]) begin
        if (stop_v[i]) begin
          m_act[i] <= 1'b0; m_done[i] <= 1'b0;
        end else if (!cfg_loop(i) && (m_t[i] + 1 == cfg_len(i) * period)) begin
          m_act[i] <= 1'b0; m_done[i] <= 1'b1;
        end else begin
          m_t[i] <= m_t[i] + 1; m_done[i] <= 1'b0;
        end
      end else begin
        m_done[i] <= 1'b0;
        if (start_v[i] && !stop_v[i]) begin
          m_act[i] <= 1'b1; m_t[i] <= 0;
        end
      end
    end
  end

  function automatic logic [3:0] exp_step(input int i);
    int period;
    period = cfg_dur(i) + cfg_gap(i);
    if (!m_act[i]) return 4'd0;
    return 4'((m_t[i] / period) % cfg_len(i));
  endfunction

  function automatic logic exp_spk(input int i);
    int         period;
    logic [63:0] s;
    logic [3:0]  e;
    period = cfg_dur(i) + cfg_gap(i);
    if (!m_act[i]) return 1'b0;
    if ((m_t[i] % period) >= cfg_dur(i)) return 1'b0;
    s = cfg_seq(i) >> (4 * int'(exp_step(i)));
    e = s[3:0];
    if (e[3]) return 1'b0;
    return m_pch[e[2:0]];
  endfunction

  task automatic check(input string nm, input int inst, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // Continuous comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check("busy", i, 16'(busy_w[i]), 16'(m_act[i]));
        check("step", i, 16'(step_w[i]), 16'(exp_step(i)));
        check("spk",  i, 16'(spk_w[i]),  16'(exp_spk(i)));
        check("done", i, 16'(done_w[i]), 16'(m_done[i]));
      end
    end
  end

  always @(negedge clk) begin
    if (ch_rand) ch = 8'($urandom);
  end

  task automatic wait_step(input int i, input logic [3:0] s, input int maxc);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < maxc && !ok; c++) begin
      if (busy_w[i] === 1'b1 && step_w[i] === s) ok = 1'b1;
      else @(negedge clk);
    end
    check("wait_step", i, 16'(ok), 16'd1);
  endtask

  task automatic pulse_start(input int i);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  typedef struct {
    bit         start;
    bit         stop;
    int         wait_c;
    logic       exp_busy;
    logic [3:0] exp_step;
    logic       exp_done;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt, dcnt, scnt, hcnt;
    logic [3:0] prev;

    for (int i = 0; i < NI; i++) begin
      rst_v[i] = 1'b1; start_v[i] = 1'b0; stop_v[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_busy", i, 16'(busy_w[i]), 16'd0);
      check("rst_step", i, 16'(step_w[i]), 16'd0);
      check("rst_spk",  i, 16'(spk_w[i]),  16'd0);
      check("rst_done", i, 16'(done_w[i]), 16'd0);
      rst_v[i] = 1'b0;
    end
    chk_en = 1'b1;

    // Default-parameter timeline: 8 steps of 4+2 cycles, done 48 cycles after first busy.
    tbl[0] = '{1'b1, 1'b0, 1,  1'b1, 4'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 5,  1'b1, 4'd0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1,  1'b1, 4'd1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 41, 1'b1, 4'd7, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1,  1'b0, 4'd0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1,  1'b0, 4'd0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 3,  1'b0, 4'd0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 2,  1'b0, 4'd0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      start_v[0] = tbl[k].start;
      stop_v[0]  = tbl[k].stop;
      repeat (tbl[k].wait_c) @(negedge clk);
      check("tbl_busy", k, 16'(busy_w[0]), 16'(tbl[k].exp_busy));
      check("tbl_step", k, 16'(step_w[0]), 16'(tbl[k].exp_step));
      check("tbl_done", k, 16'(done_w[0]), 16'(tbl[k].exp_done));
    end
    start_v[0] = 1'b0; stop_v[0] = 1'b0;

    // Looping instance: steps wrap 0,1,2,0..., never done; stop at step 1.
    pulse_start(2);
    prev = step_w[2]; dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (step_w[2] !== prev) begin
        check("loop_next", 2, 16'(step_w[2]), 16'((int'(prev) + 1) % 3));
        prev = step_w[2];
      end
      if (done_w[2] === 1'b1) dcnt++;
    end
    check("loop_done_cnt", 2, 16'(dcnt), 16'd0);
    wait_step(2, 4'd1, 40);
    stop_v[2] = 1'b1;
    @(negedge clk);
    stop_v[2] = 1'b0;
    check("stop_busy", 2, 16'(busy_w[2]), 16'd0);
    check("stop_spk",  2, 16'(spk_w[2]),  16'd0);
    check("stop_step", 2, 16'(step_w[2]), 16'd0);

    // Reset mid-playback at step 4: outputs clear, no done afterwards.
    pulse_start(0);
    wait_step(0, 4'd4, 60);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    check("midrst_busy", 0, 16'(busy_w[0]), 16'd0);
    check("midrst_step", 0, 16'(step_w[0]), 16'd0);
    check("midrst_spk",  0, 16'(spk_w[0]),  16'd0);
    check("midrst_done", 0, 16'(done_w[0]), 16'd0);
    dcnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) dcnt++;
    end
    check("midrst_done_cnt", 0, 16'(dcnt), 16'd0);

    // GAP=0, DUR=1: one step per cycle, done 8 cycles after first busy cycle.
    pulse_start(3);
    check("gap0_busy", 3, 16'(busy_w[3]), 16'd1);
    cnt = 0;
    for (int c = 0; c < 20 && done_w[3] !== 1'b1; c++) begin
      if (busy_w[3] === 1'b1) check("gap0_step", 3, 16'(step_w[3]), 16'(cnt));
      @(negedge clk);
      cnt++;
    end
    check("gap0_done_lat", 3, 16'(cnt), 16'd8);

    // Rest entry at step 2: silent for the whole step, step timing unchanged.
    ch_rand = 1'b0;
    ch = 8'hFF;
    pulse_start(1);
    scnt = 0; hcnt = 0;
    for (int c = 0; c < 60 && busy_w[1] === 1'b1; c++) begin
      if (step_w[1] === 4'd2) begin
        scnt++;
        if (spk_w[1] === 1'b1) hcnt++;
      end
      @(negedge clk);
    end
    check("rest_len",  1, 16'(scnt), 16'd6);
    check("rest_high", 1, 16'(hcnt), 16'd0);
    ch_rand = 1'b1;
    repeat (3) @(negedge clk);

    // Randomised control traffic on all instances.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) begin
        rst_v[i]   = ($urandom_range(0, 199) == 0);
        start_v[i] = ($urandom_range(0, 7) == 0);
        stop_v[i]  = ($urandom_range(0, 59) == 0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < NI; i++) begin
      rst_v[i] = 1'b0; start_v[i] = 1'b0; stop_v[i] = 1'b0;
    end
    repeat (60) @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/melody_seq.md
MELODY_SEQ -- requirements
Module: melody_seq

Interface
REQ-001 The module SHALL have parameter DUR, default 4, meaning clk cycles each note sounds (legal range 1..2^16-1).
REQ-002 The module SHALL have parameter GAP, default 2, meaning clk cycles of silence after each note (legal range 0..255).
REQ-003 The module SHALL have parameter LEN, default 8, meaning number of sequence steps played (legal range 1..16).
REQ-004 The module SHALL have parameter LOOP, default 0; when 1, playback wraps from the last step to step 0 instead of stopping.
REQ-005 The module SHALL have parameter SEQ, 64 bits, default 64'h0000_0000_7654_3210; entry i SHALL be SEQ[4i+3:4i], where bit 3 means rest and bits 2:0 select channel.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have port start, input, 1 bit: level sampled each cycle; begins playback from IDLE.
REQ-009 The module SHALL have port stop, input, 1 bit: aborts playback from any state.
REQ-010 The module SHALL have port ch, input, 8 bits: square waves from the 8-channel note generator, ch[0]..ch[7].
REQ-011 The module SHALL have port spk, output, 1 bit: registered speaker drive.
REQ-012 The module SHALL have port busy, output, 1 bit: high in PLAY and SIL.
REQ-013 The module SHALL have port step, output, 4 bits: current sequence index.
REQ-014 The module SHALL have port done, output, 1 bit: one-cycle pulse at natural end of a non-looping sequence.

Function
REQ-015 The FSM SHALL have states IDLE, PLAY and SIL.
REQ-016 In IDLE, start=1 and stop=0 SHALL move the FSM to PLAY on the next edge, with step=0 and the duration counter at 0.
REQ-017 In PLAY, the FSM SHALL remain exactly DUR cycles, then go to SIL; if GAP=0 it SHALL go directly to the step-advance decision.
REQ-018 In SIL, the FSM SHALL remain exactly GAP cycles, then advance.
REQ-019 On advance, if step<LEN-1, step SHALL increment and the FSM SHALL enter PLAY.
REQ-020 On advance at step=LEN-1 with LOOP=1, step SHALL wrap to 0 and the FSM SHALL enter PLAY with no extra cycle.
REQ-021 On advance at step=LEN-1 with LOOP=0, the FSM SHALL enter IDLE and done SHALL pulse high for exactly that first IDLE cycle.
REQ-022 spk SHALL register ch[SEQ entry[2:0]] during PLAY when entry bit 3 is 0, and SHALL register 0 during SIL, IDLE or a rest entry; spk has 1-cycle latency versus ch.
REQ-023 A stop asserted in PLAY or SIL SHALL force IDLE on the next edge, with step=0, spk=0 and no done pulse.
REQ-024 A start asserted while busy SHALL be ignored.
REQ-025 When start and stop are both high in IDLE, stop SHALL win and the FSM SHALL stay in IDLE.
REQ-026 The duration counter SHALL be 16 bits, reset to 0 on every state entry, and SHALL never wrap within a state.

Reset
REQ-027 While rst=1 at an edge, the next state SHALL be IDLE with step=0, spk=0, busy=0, done=0 and counters at 0.
REQ-028 rst SHALL take priority over start and stop.
REQ-029 rst asserted mid-playback SHALL abort it without a done pulse.

Structure
REQ-030 A shared package melody_pkg SHALL hold the state encodings (IDLE=0, PLAY=1, SIL=2), the REST bit position (3) and the entry width (4).
REQ-031 The cycle counter with terminal-count compare SHALL be one sub-module, dur_timer (inputs clr and limit; output tc).
REQ-032 The entry-select mux and FSM SHALL live in melody_seq.

Verification
REQ-033 With defaults and a 1-cycle start pulse: busy rises next cycle, step goes 0..7, each step lasts 4 PLAY plus 2 SIL cycles, done pulses once 48 cycles after the first busy cycle, and busy then falls.
REQ-034 With ch driven to distinct constant patterns: during step k, spk equals ch[k] delayed 1 cycle, and spk=0 throughout every SIL window.
REQ-035 With SEQ entry 2 = 4'h8 (rest): spk stays 0 for all of step 2 while timing is unchanged.
REQ-036 With LOOP=1 and LEN=3: step sequence is 0,1,2,0,1,2..., done never asserts, and stop at step 1 gives IDLE with spk=0 on the next cycle.
REQ-037 rst asserted during step 4 gives all outputs 0 on the next cycle and no done pulse; start held together with stop in IDLE keeps busy=0.
REQ-038 With GAP=0 and DUR=1: step increments every cycle, spk is never forced low between notes, and done pulses 8 cycles after start.
